// File: rtl/pic_if.sv
// pic_if: CPU/device-side bundle of the interrupt controller (requests, acknowledge, register bus)
//   irq     device request lines        intack  CPU acknowledge pulse
//   int_out interrupt request to CPU    vector  vector latched on intack
//   reg_sel/reg_wr/wdata register write port, rdata combinational read
interface pic_if #(parameter int NUM_IRQ = 8);
  logic [NUM_IRQ-1:0] irq;
  logic               intack;
  logic               int_out;
  logic [15:0]        vector;
  logic [1:0]         reg_sel;
  logic               reg_wr;
  logic [15:0]        wdata;
  logic [15:0]        rdata;
  modport master (output irq, intack, reg_sel, reg_wr, wdata, input int_out, vector, rdata);
  modport slave (input irq, intack, reg_sel, reg_wr, wdata, output int_out, vector, rdata);
endinterface

// File: rtl/pic_ctrl.sv
// pic_ctrl: prioritised interrupt controller with MASK/TRIG/PEND/ISR registers and nested service
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         pic_if.slave: irq, intack, reg_sel/reg_wr/wdata in; int_out, vector, rdata out
//   PIC_ROTATE_PRIORITY_EN  when defined, EOI rotates priority so the serviced channel drops to lowest
module pic_ctrl #(
  parameter int          NUM_IRQ  = 8,
  parameter logic [15:0] VEC_BASE = 16'h0000
) (
  input logic clk,
  input logic rst_n,
  pic_if.slave bus
);
  localparam int N = NUM_IRQ;
  typedef logic [N-1:0] vec_t;
  vec_t mask, trig, pend, isr, irq_q;
  vec_t edge_s, wclr, aclr, pbase, pend_n, mask_n, isr_n;
  logic [3:0] ptr, ptr_n;
  logic [4:0] win, eoi, win_n, top_n;
  logic wr_mask, wr_trig, wr_pend, wr_isr, eoi_v, int_n, int_r;
  logic [15:0] vec_r;
  logic unused_wdata;
  // {found, index} of the highest-priority set bit; scanning from lowest to highest lets the last hit win
  function automatic logic [4:0] pick(input vec_t v, input logic [3:0] p);
    logic [4:0] r;
    int j;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(p) + k) % N;
      if (v[j]) r = {1'b1, 4'(j)};
    end
    return r;
  endfunction
  function automatic logic [3:0] rank(input logic [3:0] i, input logic [3:0] p);
    return 4'((int'(i) - int'(p) + N) % N);
  endfunction
  assign wr_mask = bus.reg_wr && bus.reg_sel == 2'd0;
  assign wr_trig = bus.reg_wr && bus.reg_sel == 2'd1;
  assign wr_pend = bus.reg_wr && bus.reg_sel == 2'd2;
  assign wr_isr  = bus.reg_wr && bus.reg_sel == 2'd3;
  assign win     = pick(pend & ~mask, ptr);
  assign eoi     = pick(isr, ptr);
  assign eoi_v   = wr_isr && eoi[4];
  assign edge_s  = bus.irq & ~irq_q & trig;
  assign wclr    = wr_pend ? bus.wdata[N-1:0] & trig : '0;
  assign aclr    = bus.intack && win[4] ? trig & (vec_t'(1) << win[3:0]) : '0;
  // level bits are never cleared, so wclr/aclr only ever touch edge bits
  assign pbase   = pend & ~wclr & ~aclr;
  assign pend_n  = (trig & (pbase | edge_s)) | (~trig & bus.irq);
  assign mask_n  = wr_mask ? bus.wdata[N-1:0] : mask;
  // EOI retires the old top bit before the acknowledged winner is marked in service
  assign isr_n   = (eoi_v ? isr & ~(vec_t'(1) << eoi[3:0]) : isr) |
                   (bus.intack && win[4] ? vec_t'(1) << win[3:0] : '0);
`ifdef PIC_ROTATE_PRIORITY_EN
  assign ptr_n = eoi_v ? (eoi[3:0] == 4'(N - 1) ? 4'd0 : eoi[3:0] + 4'd1) : ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else ptr <= ptr_n;
`else
  assign ptr   = '0;
  assign ptr_n = '0;
`endif
  // int_out looks at the post-edge MASK/ISR/pointer so acks, EOIs and mask writes show next cycle,
  // but at the pre-edge PEND so a new edge takes one extra cycle to reach the CPU
  assign win_n = pick(pbase & ~mask_n, ptr_n);
  assign top_n = pick(isr_n, ptr_n);
  assign int_n = win_n[4] && (!top_n[4] || rank(win_n[3:0], ptr_n) < rank(top_n[3:0], ptr_n));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mask  <= '1;
      trig  <= '0;
      pend  <= '0;
      isr   <= '0;
      irq_q <= '0;
      int_r <= 1'b0;
      vec_r <= VEC_BASE;
    end else begin
      mask  <= mask_n;
      trig  <= wr_trig ? bus.wdata[N-1:0] : trig;
      pend  <= pend_n;
      isr   <= isr_n;
      irq_q <= bus.irq;
      int_r <= int_n;
      if (bus.intack) vec_r <= VEC_BASE + (win[4] ? 16'(win[3:0]) : 16'(N));
    end
  assign bus.int_out = int_r;
  assign bus.vector  = vec_r;
  assign bus.rdata   = bus.reg_sel == 2'd0 ? 16'(mask) :
                       bus.reg_sel == 2'd1 ? 16'(trig) :
                       bus.reg_sel == 2'd2 ? 16'(pend) : 16'(isr);
  assign unused_wdata = ^bus.wdata;
endmodule

// File: tb/tb_pic_ctrl.sv
// tb_pic_ctrl: directed and randomized checks of pic_ctrl against a behavioural model
module tb_pic_ctrl;
  localparam int N = 8;
  localparam logic [15:0] VB = 16'h0000;
`ifdef PIC_ROTATE_PRIORITY_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  pic_if #(.NUM_IRQ(N)) bus ();
  pic_ctrl #(.NUM_IRQ(N), .VEC_BASE(VB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  bit [15:0] m_mask, m_trig, m_pend, m_isr, m_irqq, m_vec;
  bit m_int;
  int m_ptr;
  localparam bit [15:0] AM = 16'((1 << N) - 1);

  function automatic int rank(int i);
    return (i - m_ptr + N) % N;
  endfunction
  function automatic int best(bit [15:0] v);
    int b = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && (b < 0 || rank(i) < rank(b))) b = i;
    return b;
  endfunction
  task automatic m_reset();
    m_mask = AM; m_trig = 0; m_pend = 0; m_isr = 0; m_irqq = 0;
    m_vec = VB; m_int = 0; m_ptr = 0;
  endtask
  task automatic m_step();
    bit [15:0] irq, wd, edg, wc, ac, pb, np;
    bit wr;
    int sel, w, e, w2, t;
    irq = 16'(bus.irq);
    wr = bus.reg_wr;
    sel = int'(bus.reg_sel);
    wd = bus.wdata & AM;
    w = best(m_pend & ~m_mask);
    e = best(m_isr);
    edg = irq & ~m_irqq & m_trig;
    wc = (wr && sel == 2) ? wd & m_trig : 16'h0;
    ac = (bus.intack && w >= 0) ? (16'(1) << w) & m_trig : 16'h0;
    pb = m_pend & ~wc & ~ac;
    np = (m_trig & (pb | edg)) | (~m_trig & irq);
    if (bus.intack) m_vec = VB + 16'(w >= 0 ? w : N);
    if (wr && sel == 3 && e >= 0) begin
      m_isr[e] = 1'b0;
      if (ROT) m_ptr = (e + 1) % N;
    end
    if (bus.intack && w >= 0) m_isr[w] = 1'b1;
    if (wr && sel == 0) m_mask = wd;
    if (wr && sel == 1) m_trig = wd;
    w2 = best(pb & ~m_mask);
    t = best(m_isr);
    m_int = w2 >= 0 && (t < 0 || rank(w2) < rank(t));
    m_pend = np;
    m_irqq = irq;
  endtask
  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      chk("model int_out", 16'(bus.int_out), 16'(m_int));
      chk("model vector", bus.vector, m_vec);
      chk("model rdata", bus.rdata,
          bus.reg_sel == 2'd0 ? m_mask : bus.reg_sel == 2'd1 ? m_trig :
          bus.reg_sel == 2'd2 ? m_pend : m_isr);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(logic [1:0] sel, logic [15:0] d);
    bus.reg_sel = sel; bus.wdata = d; bus.reg_wr = 1'b1;
    tick();
    bus.reg_wr = 1'b0;
  endtask
  task automatic ack();
    bus.intack = 1'b1;
    tick();
    bus.intack = 1'b0;
  endtask
  task automatic pulse(logic [N-1:0] v);
    bus.irq = v;
    tick();
    bus.irq = '0;
  endtask
  task automatic rd(logic [1:0] sel, string name, logic [15:0] exp);
    bus.reg_sel = sel;
    #1;
    chk(name, bus.rdata, exp);
  endtask

  initial begin
    bus.irq = '0; bus.intack = 1'b0; bus.reg_sel = 2'd0; bus.reg_wr = 1'b0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    rd(2'd0, "reset mask", 16'h00FF);
    rd(2'd1, "reset trig", 16'h0000);
    rd(2'd3, "reset isr", 16'h0000);
    chk("reset int_out", 16'(bus.int_out), 16'h0);
    chk("reset vector", bus.vector, VB);
    // single edge channel: latency, ack, EOI
    wr(2'd0, 16'h0000);
    wr(2'd1, 16'h00FF);
    pulse(8'h04);
    chk("edge latency n+1", 16'(bus.int_out), 16'h0);
    tick();
    chk("edge latency n+2", 16'(bus.int_out), 16'h1);
    ack();
    chk("ch2 vector", bus.vector, 16'h0002);
    rd(2'd3, "ch2 isr", 16'h0004);
    rd(2'd2, "ch2 pend", 16'h0000);
    chk("ch2 int after ack", 16'(bus.int_out), 16'h0);
    wr(2'd3, 16'h0000);
    rd(2'd3, "ch2 eoi", 16'h0000);
    // simultaneous edges resolve by priority
    pulse(8'h22);
    tick();
    chk("dual int", 16'(bus.int_out), 16'h1);
    ack();
    chk("dual first vector", bus.vector, 16'h0001);
    chk("dual int blocked", 16'(bus.int_out), 16'h0);
    wr(2'd3, 16'h0000);
    chk("dual int after eoi", 16'(bus.int_out), 16'h1);
    ack();
    chk("dual second vector", bus.vector, 16'h0005);
    wr(2'd3, 16'h0000);
    // nesting: higher priority preempts, lower waits for EOI
    pulse(8'h08);
    tick();
    ack();
    rd(2'd3, "nest isr ch3", 16'h0008);
    pulse(8'h02);
    tick();
    chk("nest ch1 int", 16'(bus.int_out), 16'h1);
    ack();
    chk("nest ch1 vector", bus.vector, 16'h0001);
    rd(2'd3, "nest isr both", 16'h000A);
    wr(2'd3, 16'h0000);
    rd(2'd3, "nest eoi ch1", 16'h0008);
    pulse(8'h40);
    tick();
    chk("nest ch6 held", 16'(bus.int_out), 16'h0);
    rd(2'd2, "nest ch6 pend", 16'h0040);
    wr(2'd3, 16'h0000);
    chk("nest ch6 after eoi", 16'(bus.int_out), 16'h1);
    ack();
    chk("nest ch6 vector", bus.vector, 16'h0006);
    wr(2'd3, 16'h0000);
    rd(2'd3, "nest isr empty", 16'h0000);
    // fully masked level channel gives a spurious vector
    wr(2'd0, 16'h00FF);
    wr(2'd1, 16'h0000);
    bus.irq = 8'h01;
    tick();
    tick();
    chk("masked int", 16'(bus.int_out), 16'h0);
    rd(2'd2, "masked pend", 16'h0001);
    ack();
    chk("spurious vector", bus.vector, 16'h0008);
    rd(2'd3, "spurious isr", 16'h0000);
    bus.irq = '0;
    tick();
`ifdef PIC_ROTATE_PRIORITY_EN
    wr(2'd0, 16'h0000);
    wr(2'd1, 16'h00FF);
    pulse(8'h01);
    tick();
    ack();
    chk("rot ch0 vector", bus.vector, 16'h0000);
    wr(2'd3, 16'h0000);
    pulse(8'h11);
    tick();
    ack();
    chk("rot ch4 first", bus.vector, 16'h0004);
    wr(2'd3, 16'h0000);
    ack();
    chk("rot ch0 second", bus.vector, 16'h0000);
    wr(2'd3, 16'h0000);
`endif
    // asynchronous reset in mid-service
    wr(2'd0, 16'h0000);
    wr(2'd1, 16'h00FF);
    pulse(8'h04);
    tick();
    ack();
    pulse(8'h01);
    tick();
    chk("pre-reset int", 16'(bus.int_out), 16'h1);
    rd(2'd3, "pre-reset isr", 16'h0004);
    #1 rst_n = 1'b0;
    #1 chk("async int_out", 16'(bus.int_out), 16'h0);
    chk("async isr", bus.rdata, 16'h0000);
    rd(2'd0, "async mask", 16'h00FF);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick();
    chk("post-reset int", 16'(bus.int_out), 16'h0);
    chk("post-reset vector", bus.vector, VB);
    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      bus.irq = bus.irq ^ N'($urandom & $urandom & $urandom);
      bus.intack = ($urandom % 6) == 0;
      bus.reg_sel = 2'($urandom);
      bus.reg_wr = ($urandom % 5) == 0;
      bus.wdata = 16'($urandom);
      if (bus.reg_wr && bus.reg_sel == 2'd0) bus.wdata = 16'($urandom & $urandom);
      tick();
    end
    bus.intack = 1'b0;
    bus.reg_wr = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
